gray_decade_counter: RTL and testbench

GRAY_DECADE_COUNTER -- requirements
Module: gray_decade_counter

---
 rtl/gray_decade_pkg.sv | 78 +++++++
 rtl/gray_decade_digit.sv | 16 +
 rtl/gray_decade_counter.sv | 67 ++++++
 tb/tb_gray_decade_counter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_decade_pkg.sv
// gray_decade_pkg: shared digit code table and code/BCD conversion helpers
package gray_decade_pkg;
    localparam int CODE_W = 5;
    localparam int BCD_W = 4;
    localparam logic [CODE_W-1:0] C0 = 5'b00000;
    localparam logic [CODE_W-1:0] C1 = 5'b00001;
    localparam logic [CODE_W-1:0] C2 = 5'b00011;
    localparam logic [CODE_W-1:0] C3 = 5'b00010;
    localparam logic [CODE_W-1:0] C4 = 5'b00110;
    localparam logic [CODE_W-1:0] C5 = 5'b00100;
    localparam logic [CODE_W-1:0] C6 = 5'b01100;
    localparam logic [CODE_W-1:0] C7 = 5'b01000;
    localparam logic [CODE_W-1:0] C8 = 5'b11000;
    localparam logic [CODE_W-1:0] C9 = 5'b10000;

    // Values above 9 map to code 0 so an out-of-range load clears the digit.
    function automatic logic [CODE_W-1:0] val2code(input logic [BCD_W-1:0] v);
        case (v)
            4'd0: return C0;
            4'd1: return C1;
            4'd2: return C2;
            4'd3: return C3;
            4'd4: return C4;
            4'd5: return C5;
            4'd6: return C6;
            4'd7: return C7;
            4'd8: return C8;
            4'd9: return C9;
            default: return C0;
        endcase
    endfunction

    function automatic logic [BCD_W-1:0] code2bcd(input logic [CODE_W-1:0] c);
        case (c)
            C0: return 4'd0;
            C1: return 4'd1;
            C2: return 4'd2;
            C3: return 4'd3;
            C4: return 4'd4;
            C5: return 4'd5;
            C6: return 4'd6;
            C7: return 4'd7;
            C8: return 4'd8;
            C9: return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [CODE_W-1:0] code_next_up(input logic [CODE_W-1:0] c);
        case (c)
            C0: return C1;
            C1: return C2;
            C2: return C3;
            C3: return C4;
            C4: return C5;
            C5: return C6;
            C6: return C7;
            C7: return C8;
            C8: return C9;
            default: return C0;
        endcase
    endfunction

    function automatic logic [CODE_W-1:0] code_next_down(input logic [CODE_W-1:0] c);
        case (c)
            C0: return C9;
            C2: return C1;
            C3: return C2;
            C4: return C3;
            C5: return C4;
            C6: return C5;
            C7: return C6;
            C8: return C7;
            C9: return C8;
            default: return C0;
        endcase
    endfunction
endpackage

// File: rtl/gray_decade_digit.sv
// gray_decade_digit: next-code and terminal-value logic for one decade digit
module gray_decade_digit
    import gray_decade_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    input  logic              step_i,
    input  logic              up_i,
    output logic [CODE_W-1:0] next_o,
    output logic              at_terminal_o
);
    // Invalid codes never match C9/C0, so they cannot propagate a carry.
    always_comb begin
        next_o = step_i ? (up_i ? code_next_up(code_i) : code_next_down(code_i)) : code_i;
        at_terminal_o = up_i ? (code_i == C9) : (code_i == C0);
    end
endmodule

// File: rtl/gray_decade_counter.sv
// gray_decade_counter: prescaled up/down decade counter with single-bit-change digit codes
module gray_decade_counter
    import gray_decade_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic                         i_up,
    input  logic                         i_load,
    input  logic [BCD_W*NUM_DIGITS-1:0]  i_load_bcd,
    output logic [CODE_W*NUM_DIGITS-1:0] o_code,
    output logic [BCD_W*NUM_DIGITS-1:0]  o_bcd,
    output logic                         o_tick,
    output logic                         o_wrap
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] psc_q, psc_d;
    logic [CODE_W*NUM_DIGITS-1:0] code_q, code_d, code_nx, load_code;
    logic [NUM_DIGITS:0] step;
    logic [NUM_DIGITS-1:0] term;
    logic tick, tick_q, wrap_q;

    assign tick = i_en && !i_load && psc_q == PS_MAX;
    assign step[0] = tick;

    // A step ripples upward only while every lower digit sits at its terminal value.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        gray_decade_digit u_digit (
            .code_i       (code_q[k*CODE_W +: CODE_W]),
            .step_i       (step[k]),
            .up_i         (i_up),
            .next_o       (code_nx[k*CODE_W +: CODE_W]),
            .at_terminal_o(term[k])
        );
        assign step[k+1] = step[k] & term[k];
        assign load_code[k*CODE_W +: CODE_W] = val2code(i_load_bcd[k*BCD_W +: BCD_W]);
        assign o_bcd[k*BCD_W +: BCD_W] = code2bcd(code_q[k*CODE_W +: CODE_W]);
    end

    always_comb begin
        psc_d = i_load ? '0 : !i_en ? psc_q : tick ? '0 : psc_q + 1'b1;
        code_d = i_load ? load_code : code_nx;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            psc_q <= '0;
            code_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            psc_q <= psc_d;
            code_q <= code_d;
            tick_q <= tick;
            wrap_q <= step[NUM_DIGITS];
        end
    end

    assign o_code = code_q;
    assign o_tick = tick_q;
    assign o_wrap = wrap_q;
endmodule

// File: tb/tb_gray_decade_counter.sv
// tb_gray_decade_counter: random and directed checks of two counter configurations against a decimal model
module tb_gray_decade_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst, a_en, a_up, a_load, a_tick, a_wrap;
    logic [7:0] a_lbcd, a_bcd;
    logic [9:0] a_code, a_prev;
    logic b_rst, b_en, b_up, b_load, b_tick, b_wrap;
    logic [15:0] b_lbcd, b_bcd;
    logic [19:0] b_code;

    int n_chk = 0, n_err = 0;
    int a_val, a_psc, b_val, b_psc;
    bit a_tk, a_wr, b_tk, b_wr, b_mdl = 1'b1;
    logic [4:0] gtab [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
                              5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000};

    gray_decade_counter #(.NUM_DIGITS(2), .PRESCALE(1)) u_a (
        .i_clk(clk), .i_rst(a_rst), .i_en(a_en), .i_up(a_up), .i_load(a_load),
        .i_load_bcd(a_lbcd), .o_code(a_code), .o_bcd(a_bcd), .o_tick(a_tick), .o_wrap(a_wrap));

    gray_decade_counter #(.NUM_DIGITS(4), .PRESCALE(3)) u_b (
        .i_clk(clk), .i_rst(b_rst), .i_en(b_en), .i_up(b_up), .i_load(b_load),
        .i_load_bcd(b_lbcd), .o_code(b_code), .o_bcd(b_bcd), .o_tick(b_tick), .o_wrap(b_wrap));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Counter state held as a plain decimal integer modulo 10^nd.
    function automatic void mdl(input int nd, input int ps, input bit rst, input bit load, input bit en,
                                input bit up, input logic [31:0] lb, inout int val, inout int psc,
                                output bit tk, output bit wr);
        int m = 1;
        int d;
        for (int i = 0; i < nd; i++) m *= 10;
        tk = 1'b0;
        wr = 1'b0;
        if (rst) begin
            val = 0;
            psc = 0;
        end else if (load) begin
            val = 0;
            for (int i = nd - 1; i >= 0; i--) begin
                d = int'(lb[i*4 +: 4]);
                val = val * 10 + (d > 9 ? 0 : d);
            end
            psc = 0;
        end else if (en) begin
            if (psc == ps - 1) begin
                tk = 1'b1;
                psc = 0;
                wr = up ? (val == m - 1) : (val == 0);
                val = up ? (val + 1) % m : (val + m - 1) % m;
            end else psc++;
        end
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r = '0;
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v /= 10;
        end
        return r;
    endfunction

    function automatic logic [39:0] to_code(input int v, input int nd);
        logic [39:0] r = '0;
        for (int i = 0; i < nd; i++) begin
            r[i*5 +: 5] = gtab[v % 10];
            v /= 10;
        end
        return r;
    endfunction

    task automatic cyc();
        mdl(2, 1, a_rst, a_load, a_en, a_up, 32'(a_lbcd), a_val, a_psc, a_tk, a_wr);
        mdl(4, 3, b_rst, b_load, b_en, b_up, 32'(b_lbcd), b_val, b_psc, b_tk, b_wr);
        @(posedge clk);
        #1;
        chk("a_bcd", 64'(a_bcd), 64'(to_bcd(a_val, 2)));
        chk("a_code", 64'(a_code), 64'(to_code(a_val, 2)));
        chk("a_tick", 64'(a_tick), 64'(a_tk));
        chk("a_wrap", 64'(a_wrap), 64'(a_wr));
        if (b_mdl) begin
            chk("b_bcd", 64'(b_bcd), 64'(to_bcd(b_val, 4)));
            chk("b_code", 64'(b_code), 64'(to_code(b_val, 4)));
            chk("b_tick", 64'(b_tick), 64'(b_tk));
            chk("b_wrap", 64'(b_wrap), 64'(b_wr));
        end
        @(negedge clk);
    endtask

    initial begin
        int wraps, ticks, cnt;
        bit hit;
        {a_en, a_up, a_load, a_lbcd, b_en, b_up, b_load, b_lbcd} = '0;
        a_rst = 1'b1;
        b_rst = 1'b1;
        @(negedge clk);
        cyc();
        cyc();
        a_rst = 1'b0; a_en = 1'b1; a_up = 1'b1;
        b_rst = 1'b0; b_en = 1'b1; b_up = 1'b1;
        wraps = 0;
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            a_prev = a_code;
            if (i == 9) b_en = 1'b0;
            cyc();
            ticks += int'(b_tick);
            if (i == 8) begin
                chk("b_ticks_9cyc", 64'(ticks), 64'd3);
                chk("b_bcd_9cyc", 64'(b_bcd), 64'h0003);
            end
            if (a_wrap) begin
                wraps++;
                chk("a_wrap_at_00", 64'(a_bcd), 64'h00);
            end
            for (int d = 0; d < 2; d++)
                if (a_code[d*5 +: 5] != a_prev[d*5 +: 5])
                    chk("a_gray_1bit", 64'($countones(a_code[d*5 +: 5] ^ a_prev[d*5 +: 5])), 64'd1);
        end
        chk("a_wrap_count", 64'(wraps), 64'd1);
        chk("a_final_00", 64'(a_bcd), 64'h00);
        a_en = 1'b0;
        b_en = 1'b1;
        cyc();
        b_en = 1'b0;
        repeat (5) cyc();
        b_en = 1'b1;
        cnt = 6;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cyc();
            cnt++;
            hit = b_tick;
        end
        chk("b_stretched_spacing", 64'(cnt), 64'd8);
        b_en = 1'b0; b_load = 1'b1; b_lbcd = 16'h0000; b_up = 1'b0;
        cyc();
        b_load = 1'b0; b_en = 1'b1;
        repeat (3) cyc();
        chk("b_down_wrap_bcd", 64'(b_bcd), 64'h9999);
        chk("b_down_wrap_flag", 64'(b_wrap), 64'd1);
        b_en = 1'b0;
        cyc();
        chk("b_wrap_one_cycle", 64'(b_wrap), 64'd0);
        b_load = 1'b1; b_lbcd = 16'h01C9;
        cyc();
        chk("b_load_bad_nibble", 64'(b_bcd), 64'h0109);
        b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
        repeat (2) cyc();
        b_load = 1'b1; b_lbcd = 16'h4321;
        cyc();
        chk("b_load_vs_tick_tick", 64'(b_tick), 64'd0);
        chk("b_load_vs_tick_bcd", 64'(b_bcd), 64'h4321);
        b_lbcd = 16'h0050; b_en = 1'b0;
        cyc();
        b_load = 1'b0;
        b_mdl = 1'b0;
        force u_b.code_q = {gtab[0], gtab[0], gtab[5], 5'b10101};
        #1;
        chk("b_invalid_bcd_f", 64'(b_bcd), 64'h005F);
        @(posedge clk);
        #1;
        release u_b.code_q;
        @(negedge clk);
        chk("b_invalid_held", 64'(b_bcd), 64'h005F);
        b_up = 1'b0; b_en = 1'b1;
        repeat (3) cyc();
        chk("b_invalid_step_bcd", 64'(b_bcd), 64'h0050);
        chk("b_invalid_step_tick", 64'(b_tick), 64'd1);
        b_val = 50;
        b_psc = 0;
        b_mdl = 1'b1;
        b_en = 1'b0; b_load = 1'b1; b_lbcd = 16'h0958;
        cyc();
        b_load = 1'b0; b_en = 1'b1;
        cyc();
        b_rst = 1'b1;
        cyc();
        chk("b_rst_bcd", 64'(b_bcd), 64'h0000);
        chk("b_rst_tick", 64'(b_tick), 64'd0);
        chk("b_rst_wrap", 64'(b_wrap), 64'd0);
        b_rst = 1'b0;
        cnt = 0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cyc();
            cnt++;
            hit = b_tick;
        end
        chk("b_first_tick_after_rst", 64'(cnt), 64'd3);
        for (int i = 0; i < 3000; i++) begin
            a_rst = $urandom_range(63) == 0;
            a_load = $urandom_range(15) == 0;
            a_en = $urandom_range(3) != 0;
            a_up = $urandom_range(1) == 1;
            a_lbcd = 8'($urandom);
            b_rst = $urandom_range(63) == 0;
            b_load = $urandom_range(15) == 0;
            b_en = $urandom_range(3) != 0;
            b_up = $urandom_range(1) == 1;
            b_lbcd = 16'($urandom);
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
